// File: rtl/imm_encoder.sv
// LEGv8 immediate encoder: range-checks a signed byte offset, packs an LDUR/STUR/CBZ word, and queues it in a FIFO.
// Optional re-extension self-check is enabled by defining IMM_ENCODER_SELFCHECK_EN.
module imm_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rn,
    input  logic [63:0]      in_offset,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic             check_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] KIND_LDUR = 2'b00;
    localparam logic [1:0] KIND_STUR = 2'b01;
    localparam logic [1:0] KIND_CBZ  = 2'b10;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;

    logic        ldur_ok;
    logic        cbz_ok;
    logic        enc_err;
    logic [31:0] enc_word;

    always_comb begin
        ldur_ok  = (in_offset[63:8] == {56{in_offset[8]}});
        cbz_ok   = (in_offset[1:0] == 2'b00) && (in_offset[63:20] == {44{in_offset[20]}});
        enc_err  = 1'b1;
        enc_word = '0;
        case (in_kind)
            KIND_LDUR: begin
                enc_err  = !ldur_ok;
                enc_word = {OP_LDUR, in_offset[8:0], 2'b00, in_rn, in_rt};
            end
            KIND_STUR: begin
                enc_err  = !ldur_ok;
                enc_word = {OP_STUR, in_offset[8:0], 2'b00, in_rn, in_rt};
            end
            KIND_CBZ: begin
                enc_err  = !cbz_ok;
                enc_word = {OP_CBZ, in_offset[20:2], in_rt};
            end
            default: begin
                enc_err  = 1'b1;
                enc_word = '0;
            end
        endcase
        if (enc_err) begin
            enc_word = '0;
        end
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready = !full, out_valid = !empty; no bypass, so a full FIFO refuses a push even while popping.
    logic [32:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             push;
    logic             pop;
    logic [32:0]      head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_instr = out_valid ? head[31:0] : 32'h0000_0000;
    assign out_err   = out_valid && head[32];
    assign err_count = err_count_q;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && enc_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {enc_err, enc_word};
        end
    end

`ifdef IMM_ENCODER_SELFCHECK_EN
    logic [63:0] dec_off;
    logic        mismatch_d;
    logic        mismatch_q;
    logic        sticky_q;

    // Re-extend exactly as the datapath would: CB-type word-scaled imm19, D-type imm9.
    always_comb begin
        dec_off = '0;
        if (enc_word[31:24] == OP_CBZ) begin
            dec_off = {{43{enc_word[23]}}, enc_word[23:5], 2'b00};
        end else begin
            dec_off = {{55{enc_word[20]}}, enc_word[20:12]};
        end
        mismatch_d = push && !enc_err && (dec_off != in_offset);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
            if (mismatch_d) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign check_fail = mismatch_q;

    always_ff @(posedge clk) begin
        if (mismatch_q && !reset) begin
            $error("imm_encoder: re-extended offset differs from accepted offset (sticky=%0b)", sticky_q);
        end
    end
`else
    assign check_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: encodings, range boundaries, backpressure, streaming, reset.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rt;
    logic [4:0]  in_rn;
    logic [63:0] in_offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;
    logic        check_fail;

    int passed = 0;
    int total  = 0;
    int cf_seen = 0;
    logic [31:0] exp_q[$];

    imm_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rt      (in_rt),
        .in_rn      (in_rn),
        .in_offset  (in_offset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .err_count  (err_count),
        .check_fail (check_fail)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (check_fail === 1'b1) cf_seen++;
    end

    // driver tasks
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] kind, input logic [4:0] rt, input logic [4:0] rn,
                        input logic [63:0] off);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_rt     = rt;
        in_rn     = rn;
        in_offset = off;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 00000000", out_instr); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", out_err); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (check_fail !== 1'b0) $display("FAIL reset_check_fail: got %b want 0", check_fail); else passed++;
    endtask

    task automatic test_ldur_stur();
        do_reset();
        out_ready = 1'b1;
        send(2'b00, 5'd1, 5'd2, 64'd2);
        total++; if (out_valid !== 1'b1) $display("FAIL ldur_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_instr !== 32'hF8402041) $display("FAIL ldur_word: got %h want F8402041", out_instr); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL ldur_err: got %b want 0", out_err); else passed++;
        send(2'b01, 5'd0, 5'd0, -64'sd256);
        total++; if (out_instr !== 32'hF8100000) $display("FAIL stur_neg256: got %h want F8100000", out_instr); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL stur_neg256_err: got %b want 0", out_err); else passed++;
        send(2'b00, 5'd0, 5'd0, 64'd256);
        total++; if (out_err !== 1'b1) $display("FAIL ldur_256_err: got %b want 1", out_err); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL ldur_256_word: got %h want 00000000", out_instr); else passed++;
        total++; if (err_count !== 16'd1) $display("FAIL ldur_256_count: got %0d want 1", err_count); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL ldur_stur_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_cbz();
        do_reset();
        out_ready = 1'b1;
        send(2'b10, 5'd1, 5'd9, 64'd72);
        total++; if (out_instr !== 32'hB4000241) $display("FAIL cbz_72: got %h want B4000241", out_instr); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL cbz_72_err: got %b want 0", out_err); else passed++;
        send(2'b10, 5'd1, 5'd0, 64'd6);
        total++; if (out_err !== 1'b1) $display("FAIL cbz_misaligned_err: got %b want 1", out_err); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL cbz_misaligned_word: got %h want 00000000", out_instr); else passed++;
        send(2'b11, 5'd1, 5'd1, 64'd8);
        total++; if (out_err !== 1'b1) $display("FAIL kind11_err: got %b want 1", out_err); else passed++;
        total++; if (err_count !== 16'd2) $display("FAIL cbz_err_count: got %0d want 2", err_count); else passed++;
        tick();
    endtask

    task automatic test_boundaries();
        logic [1:0]  kinds [7];
        logic [4:0]  rts   [7];
        logic [4:0]  rns   [7];
        logic [63:0] offs  [7];
        logic [31:0] words [7];
        logic        errs  [7];
        kinds[0] = 2'b00; rts[0] = 5'd0;  rns[0] = 5'd0;  offs[0] = 64'd255;                 words[0] = 32'hF84FF000; errs[0] = 1'b0;
        kinds[1] = 2'b00; rts[1] = 5'd0;  rns[1] = 5'd0;  offs[1] = -64'sd257;               words[1] = 32'h0;        errs[1] = 1'b1;
        kinds[2] = 2'b10; rts[2] = 5'd3;  rns[2] = 5'd0;  offs[2] = -64'sd1048576;           words[2] = 32'hB4800003; errs[2] = 1'b0;
        kinds[3] = 2'b10; rts[3] = 5'd3;  rns[3] = 5'd0;  offs[3] = 64'd1048572;             words[3] = 32'hB47FFFE3; errs[3] = 1'b0;
        kinds[4] = 2'b10; rts[4] = 5'd3;  rns[4] = 5'd0;  offs[4] = 64'd1048576;             words[4] = 32'h0;        errs[4] = 1'b1;
        kinds[5] = 2'b01; rts[5] = 5'd31; rns[5] = 5'd31; offs[5] = -64'sd1;                 words[5] = 32'hF81FF3FF; errs[5] = 1'b0;
        kinds[6] = 2'b00; rts[6] = 5'd0;  rns[6] = 5'd0;  offs[6] = 64'h8000_0000_0000_0000; words[6] = 32'h0;        errs[6] = 1'b1;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(kinds[i], rts[i], rns[i], offs[i]);
            total++;
            if (out_instr !== words[i]) $display("FAIL boundary_word[%0d]: got %h want %h", i, out_instr, words[i]);
            else passed++;
            total++;
            if (out_err !== errs[i]) $display("FAIL boundary_err[%0d]: got %b want %b", i, out_err, errs[i]);
            else passed++;
        end
        total++; if (err_count !== 16'd3) $display("FAIL boundary_err_count: got %0d want 3", err_count); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int  pops;
        logic acc;
        logic [31:0] w;
        do_reset();
        exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 5'd0, 5'd0, 64'(i));
            exp_q.push_back(32'hF8400000 | (32'(i) << 12));
        end
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", in_ready); else passed++;
        in_valid  = 1'b1;
        in_kind   = 2'b00;
        in_rt     = 5'd0;
        in_rn     = 5'd0;
        in_offset = 64'd4;
        exp_q.push_back(32'hF8404000);
        for (int c = 0; c < 3; c++) tick();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_fifth_blocked: got %b want 0", in_ready); else passed++;
        total++; if (out_instr !== 32'hF8400000) $display("FAIL bp_head_stable: got %h want F8400000", out_instr); else passed++;
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid && out_ready) begin
                pops++;
                total++;
                if (exp_q.size() == 0) $display("FAIL bp_extra_word: got %h want none", out_instr);
                else begin
                    w = exp_q.pop_front();
                    if (out_instr !== w) $display("FAIL bp_order: got %h want %h", out_instr, w);
                    else passed++;
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        total++; if (pops != 5) $display("FAIL bp_pop_count: got %0d want 5", pops); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        int pops;
        logic [63:0] off;
        logic [31:0] w;
        do_reset();
        exp_q.delete();
        out_ready = 1'b1;
        send(2'b00, 5'd7, 5'd5, 64'd100);
        exp_q.push_back(32'hF8464000 | (32'd5 << 5) | 32'd7);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else passed++;
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_count[%0d]: got out_valid %b want 1", i, out_valid); else passed++;
            if (out_valid) begin
                pops++;
                w = exp_q.pop_front();
                total++; if (out_instr !== w) $display("FAIL b2b_order[%0d]: got %h want %h", i, out_instr, w); else passed++;
            end
            off = 64'(i * 8) - 64'd80;
            in_valid  = 1'b1;
            in_kind   = 2'b00;
            in_rt     = 5'(i);
            in_rn     = 5'd3;
            in_offset = off;
            exp_q.push_back({11'b111_1100_0010, off[8:0], 2'b00, 5'd3, 5'(i)});
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                pops++;
                w = exp_q.pop_front();
                total++; if (out_instr !== w) $display("FAIL b2b_tail: got %h want %h", out_instr, w); else passed++;
            end
            tick();
        end
        total++; if (pops != 21) $display("FAIL b2b_pop_count: got %0d want 21", pops); else passed++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(2'b11, 5'd0, 5'd0, 64'd0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b01, 5'd1, 5'd1, 64'(i * 4));
        total++; if (err_count !== 16'd5) $display("FAIL mid_err_count_pre: got %0d want 5", err_count); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL mid_valid_pre: got %b want 1", out_valid); else passed++;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_kind   = 2'b00;
        in_offset = 64'd16;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL mid_err_count: got %0d want 0", err_count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL mid_out_instr: got %h want 00000000", out_instr); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_inflight_dropped: got %b want 0", out_valid); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_kind   = 2'b00;
        in_rt     = 5'd0;
        in_rn     = 5'd0;
        in_offset = 64'd0;
        out_ready = 1'b0;
        test_reset();
        test_ldur_stur();
        test_cbz();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        total++; if (cf_seen != 0) $display("FAIL check_fail_seen: got %0d want 0", cf_seen); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
